// File: rtl/cdc_fifo_pkg.sv
// Shared types and constants for the cdc_fifo read-side packer.
package cdc_fifo_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 4;
    localparam int unsigned BEAT_COUNT_WIDTH   = 8;

endpackage

// File: rtl/cdc_fifo_word_packer.sv
// Slot-indexed assembly register: packs consecutive words into one beat, first word in the LSB slot.
module cdc_fifo_word_packer
    import cdc_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned WORDS_PER_BEAT = 2,
    parameter int unsigned BEAT_WIDTH     = DATA_WIDTH * WORDS_PER_BEAT,
    parameter int unsigned IDX_WIDTH      = $clog2(WORDS_PER_BEAT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [BEAT_WIDTH-1:0] full_beat,
    output logic [IDX_WIDTH-1:0]  idx
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORDS_PER_BEAT - 1);

    logic [BEAT_WIDTH-1:0] r_assembly;
    logic [IDX_WIDTH-1:0]  r_idx;

    // Assembly register with the incoming word merged into the current slot.
    always_comb begin
        full_beat = r_assembly;
        for (int unsigned i = 0; i < WORDS_PER_BEAT; i++) begin
            if (r_idx == IDX_WIDTH'(i)) begin
                full_beat[i*DATA_WIDTH +: DATA_WIDTH] = word;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_idx      <= '0;
            r_assembly <= '0;
        end else if (capture) begin
            if (r_idx == LAST_IDX) begin
                r_idx      <= '0;
                r_assembly <= '0;
            end else begin
                r_idx      <= r_idx + IDX_WIDTH'(1);
                r_assembly <= full_beat;
            end
        end
    end

    assign idx = r_idx;

endmodule

// File: rtl/cdc_fifo_read_packer.sv
// cdc_fifo read-side consumer: pops words, packs them into beats, presents beats on valid/ready.
// Optional CDC_FIFO_READER_COUNT_EN adds an 8-bit accepted-beat counter output.
module cdc_fifo_read_packer
    import cdc_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned WORDS_PER_BEAT = 2,
    parameter int unsigned BEAT_WIDTH     = DATA_WIDTH * WORDS_PER_BEAT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       read_data,
    input  logic                        empty,
    output logic                        read_increment,
    input  logic                        flush,
    output logic [BEAT_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef CDC_FIFO_READER_COUNT_EN
    output logic [BEAT_COUNT_WIDTH-1:0] beat_count,
`endif
    output logic                        partial
);

    localparam int unsigned IDX_WIDTH = $clog2(WORDS_PER_BEAT);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORDS_PER_BEAT - 1);

    state_t                r_state;
    logic [BEAT_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  w_pop;
    logic                  w_clear;
    logic                  w_accept;
    logic [BEAT_WIDTH-1:0] w_full_beat;
    logic [IDX_WIDTH-1:0]  w_idx;

    assign w_pop    = (r_state == COLLECT) && !empty && !flush && !reset;
    assign w_clear  = (r_state == COLLECT) && flush;
    assign w_accept = r_out_valid && out_ready;

    cdc_fifo_word_packer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .WORDS_PER_BEAT (WORDS_PER_BEAT),
        .BEAT_WIDTH     (BEAT_WIDTH),
        .IDX_WIDTH      (IDX_WIDTH)
    ) u_word_packer (
        .clock     (clock),
        .reset     (reset),
        .capture   (w_pop),
        .clear     (w_clear),
        .word      (read_data),
        .full_beat (w_full_beat),
        .idx       (w_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_pop && (w_idx == LAST_IDX)) begin
                        r_out_data  <= w_full_beat;
                        r_out_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_state     <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

`ifdef CDC_FIFO_READER_COUNT_EN
    logic [BEAT_COUNT_WIDTH-1:0] r_beat_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_beat_count <= '0;
        end else if (w_accept) begin
            r_beat_count <= r_beat_count + BEAT_COUNT_WIDTH'(1);
        end
    end

    assign beat_count = r_beat_count;
`endif

    assign read_increment = w_pop;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;
    assign partial        = (r_state == COLLECT) && (w_idx != '0);

endmodule

// File: tb/tb_cdc_fifo_read_packer.sv
// Directed self-checking bench for cdc_fifo_read_packer at the default parameters.
module tb_cdc_fifo_read_packer;

    logic       clock;
    logic       reset;
    logic [3:0] read_data;
    logic       empty;
    logic       read_increment;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       partial;
`ifdef CDC_FIFO_READER_COUNT_EN
    logic [7:0] beat_count;
`endif

    int total = 0;
    int bad   = 0;

    cdc_fifo_read_packer #(
        .DATA_WIDTH     (4),
        .WORDS_PER_BEAT (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .read_data      (read_data),
        .empty          (empty),
        .read_increment (read_increment),
        .flush          (flush),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
`ifdef CDC_FIFO_READER_COUNT_EN
        .beat_count     (beat_count),
`endif
        .partial        (partial)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; empty = 1'b1; flush = 1'b0; out_ready = 1'b0; read_data = 4'h0;
        step(); step();
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
        total++; if (partial !== 1'b0) begin bad++; $display("FAIL reset_partial got=%b exp=0", partial); end
        total++; if (read_increment !== 1'b0) begin bad++; $display("FAIL reset_inc got=%b exp=0", read_increment); end
`ifdef CDC_FIFO_READER_COUNT_EN
        total++; if (beat_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", beat_count); end
`endif
    endtask

    task automatic test_basic_beat();
        read_data = 4'h3; empty = 1'b0;
        #1;
        total++; if (read_increment !== 1'b1) begin bad++; $display("FAIL basic_inc0 got=%b exp=1", read_increment); end
        step();
        read_data = 4'hA;
        #1;
        total++; if (read_increment !== 1'b1) begin bad++; $display("FAIL basic_inc1 got=%b exp=1", read_increment); end
        total++; if (partial !== 1'b1) begin bad++; $display("FAIL basic_partial got=%b exp=1", partial); end
        step();
        read_data = 4'hF;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'hA3) begin bad++; $display("FAIL basic_data got=%h exp=a3", out_data); end
        total++; if (partial !== 1'b0) begin bad++; $display("FAIL basic_partial_off got=%b exp=0", partial); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_data !== 8'hA3) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=a3", i, out_data); end
            total++; if (read_increment !== 1'b0) begin bad++; $display("FAIL bp_inc[%0d] got=%b exp=0", i, read_increment); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++; if (read_increment !== 1'b0) begin bad++; $display("FAIL bp_accept_inc got=%b exp=0", read_increment); end
        step();
        out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_drop got=%b exp=0", out_valid); end
        total++; if (read_increment !== 1'b1) begin bad++; $display("FAIL bp_resume_inc got=%b exp=1", read_increment); end
        empty = 1'b1;
        #1;
    endtask

    task automatic test_stall();
        read_data = 4'h5; empty = 1'b0;
        step();
        empty = 1'b1; read_data = 4'hC;
        #1;
        for (int i = 0; i < 10; i++) begin
            total++; if (partial !== 1'b1) begin bad++; $display("FAIL stall_partial[%0d] got=%b exp=1", i, partial); end
            total++; if (read_increment !== 1'b0) begin bad++; $display("FAIL stall_inc[%0d] got=%b exp=0", i, read_increment); end
            step();
        end
        read_data = 4'h6; empty = 1'b0;
        step();
        empty = 1'b1;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'h65) begin bad++; $display("FAIL stall_data got=%h exp=65", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_accept got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        read_data = 4'h7; empty = 1'b0;
        step();
        flush = 1'b1; read_data = 4'h9;
        #1;
        total++; if (read_increment !== 1'b0) begin bad++; $display("FAIL flush_inc got=%b exp=0", read_increment); end
        step();
        flush = 1'b0;
        #1;
        total++; if (partial !== 1'b0) begin bad++; $display("FAIL flush_partial got=%b exp=0", partial); end
        read_data = 4'h1;
        step();
        read_data = 4'h2;
        step();
        empty = 1'b1;
        #1;
        total++; if (out_data !== 8'h21) begin bad++; $display("FAIL flush_data got=%h exp=21", out_data); end
        // flush while presenting must not drop the beat
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_present_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'h21) begin bad++; $display("FAIL flush_present_data got=%h exp=21", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_midbeat_reset();
        read_data = 4'hB; empty = 1'b0;
        step();
        reset = 1'b1;
        #1;
        total++; if (read_increment !== 1'b0) begin bad++; $display("FAIL rst_inc got=%b exp=0", read_increment); end
        step();
        reset = 1'b0; empty = 1'b1;
        #1;
        total++; if (partial !== 1'b0) begin bad++; $display("FAIL rst_partial got=%b exp=0", partial); end
        read_data = 4'h4; empty = 1'b0;
        step();
        read_data = 4'h8;
        step();
        empty = 1'b1;
        #1;
        total++; if (out_data !== 8'h84) begin bad++; $display("FAIL rst_next_data got=%h exp=84", out_data); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_present_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_present_data got=%h exp=00", out_data); end
        empty = 1'b0;
        #1;
        total++; if (read_increment !== 1'b1) begin bad++; $display("FAIL rst_collect_inc got=%b exp=1", read_increment); end
        empty = 1'b1;
        #1;
    endtask

`ifdef CDC_FIFO_READER_COUNT_EN
    task automatic test_beat_count();
        total++; if (beat_count !== 8'd0) begin bad++; $display("FAIL count_start got=%0d exp=0", beat_count); end
        read_data = 4'h1; empty = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        total++; if (beat_count !== 8'd2) begin bad++; $display("FAIL count_two got=%0d exp=2", beat_count); end
        for (int i = 0; i < 255 * 3; i++) step();
        empty = 1'b1; out_ready = 1'b0;
        #1;
        total++; if (beat_count !== 8'd1) begin bad++; $display("FAIL count_wrap got=%0d exp=1", beat_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_beat();
        test_backpressure();
        test_stall();
        test_flush();
        test_midbeat_reset();
`ifdef CDC_FIFO_READER_COUNT_EN
        test_beat_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
